step_sequencer_core: RTL and testbench

- Upstream of the audio playback stage.
- Holds the 7×16 drum pattern (row0..row6) and generates the 4-bit step counter at the programmed tempo.
- Applies user edits (toggle one cell, clear all) and runs or stops the step clock according to poweron and run.
- Outputs feed the audio stage's row0..row6, counter and poweron inputs directly.

---
 rtl/step_sequencer_core_if.sv | 31 +++
 rtl/step_sequencer_core.sv | 107 ++++++++++
 tb/tb_step_sequencer_core.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_core_if.sv
// Control/pattern bus between the drum sequencer core and its host/audio stage.
// master = host side driving controls and reading pattern/step; slave = sequencer core.
interface step_sequencer_core_if;
    logic        poweron;
    logic        run;
    logic [7:0]  bpm;
    logic        edit_toggle;
    logic [2:0]  edit_row;
    logic [3:0]  edit_step;
    logic        clear_all;
    logic [15:0] row0;
    logic [15:0] row1;
    logic [15:0] row2;
    logic [15:0] row3;
    logic [15:0] row4;
    logic [15:0] row5;
    logic [15:0] row6;
    logic [3:0]  counter;
    logic        step_tick;
    logic        running;

    modport master (
        output poweron, run, bpm, edit_toggle, edit_row, edit_step, clear_all,
        input  row0, row1, row2, row3, row4, row5, row6, counter, step_tick, running
    );

    modport slave (
        input  poweron, run, bpm, edit_toggle, edit_row, edit_step, clear_all,
        output row0, row1, row2, row3, row4, row5, row6, counter, step_tick, running
    );
endinterface

// File: rtl/step_sequencer_core.sv
// 7x16 drum pattern store plus tempo-driven 16-step counter; a phase accumulator
// adds the clamped bpm every MCLK and steps when it crosses CLK_HZ*15.
module step_sequencer_core #(
    parameter int unsigned CLK_HZ  = 12288000,
    parameter int unsigned BPM_MIN = 40,
    parameter int unsigned BPM_MAX = 240
) (
    input  logic                        MCLK,
    input  logic                        reset,
    step_sequencer_core_if.slave        bus
);
    localparam int unsigned THRESH = CLK_HZ * 15;
    localparam int unsigned ACC_W  = $clog2(THRESH + BPM_MAX + 1);
    localparam logic [ACC_W-1:0] THRESH_W  = THRESH[ACC_W-1:0];
    localparam logic [7:0]       BPM_MIN_B = BPM_MIN[7:0];
    localparam logic [7:0]       BPM_MAX_B = BPM_MAX[7:0];

    typedef enum logic {STOP, RUN} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       counter_q, counter_d;
    logic             tick_q, tick_d;
    logic [15:0]      rows_q [7];
    logic [15:0]      rows_d [7];

    logic [7:0]       bpm_c;
    logic [ACC_W-1:0] nxt;
    logic             go;

    always_comb begin
        if (bus.bpm < BPM_MIN_B)      bpm_c = BPM_MIN_B;
        else if (bus.bpm > BPM_MAX_B) bpm_c = BPM_MAX_B;
        else                          bpm_c = bus.bpm;
    end

    assign go  = bus.poweron & bus.run;
    assign nxt = acc_q + ACC_W'(bpm_c);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        counter_d = counter_q;
        tick_d    = 1'b0;
        case (state_q)
            STOP: begin
                acc_d     = '0;
                counter_d = '0;
                // Entry edge is the start cycle: step 0 sounds immediately.
                if (go) begin
                    state_d = RUN;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (!go) begin
                    state_d   = STOP;
                    acc_d     = '0;
                    counter_d = '0;
                end else if (nxt >= THRESH_W) begin
                    acc_d     = nxt - THRESH_W;
                    counter_d = counter_q + 4'd1;
                    tick_d    = 1'b1;
                end else begin
                    acc_d = nxt;
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_comb begin
        rows_d = rows_q;
        if (bus.clear_all) begin
            rows_d = '{default: '0};
        end else if (bus.edit_toggle && bus.edit_row != 3'd7) begin
            rows_d[bus.edit_row][bus.edit_step] = ~rows_q[bus.edit_row][bus.edit_step];
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q   <= STOP;
            acc_q     <= '0;
            counter_q <= '0;
            tick_q    <= 1'b0;
            rows_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            counter_q <= counter_d;
            tick_q    <= tick_d;
            rows_q    <= rows_d;
        end
    end

    assign bus.row0      = rows_q[0];
    assign bus.row1      = rows_q[1];
    assign bus.row2      = rows_q[2];
    assign bus.row3      = rows_q[3];
    assign bus.row4      = rows_q[4];
    assign bus.row5      = rows_q[5];
    assign bus.row6      = rows_q[6];
    assign bus.counter   = counter_q;
    assign bus.step_tick = tick_q;
    assign bus.running   = (state_q == RUN);
endmodule

// File: tb/tb_step_sequencer_core.sv
// Bench for step_sequencer_core at CLK_HZ=1000 (THRESH=15000): tick spacing and
// step order via an expectation queue, plus edit/clear/stop/reset behaviour.
module tb_step_sequencer_core;
    logic MCLK = 1'b0;
    logic reset;

    always #5 MCLK = ~MCLK;

    step_sequencer_core_if bus ();

    step_sequencer_core #(
        .CLK_HZ (1000),
        .BPM_MIN(40),
        .BPM_MAX(240)
    ) dut (
        .MCLK (MCLK),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] gap;
        logic [3:0]  cnt;
    } tick_exp_t;

    tick_exp_t   exp_q[$];
    logic [15:0] exp_rows [7];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] row_of(input int r);
        case (r)
            0:       return bus.row0;
            1:       return bus.row1;
            2:       return bus.row2;
            3:       return bus.row3;
            4:       return bus.row4;
            5:       return bus.row5;
            default: return bus.row6;
        endcase
    endfunction

    task automatic check_rows(input string tag);
        for (int r = 0; r < 7; r++)
            check_val($sformatf("%s_row%0d", tag, r), {16'h0, row_of(r)}, {16'h0, exp_rows[r]});
    endtask

    task automatic push_tick(input int unsigned gap, input int unsigned cnt);
        tick_exp_t e;
        e.gap = 16'(gap);
        e.cnt = 4'(cnt);
        exp_q.push_back(e);
    endtask

    // Counts negedges until step_tick is seen, bounded so a dead DUT cannot hang the run.
    task automatic wait_tick(output int unsigned gap);
        gap = 0;
        do begin
            @(negedge MCLK);
            gap++;
        end while (bus.step_tick !== 1'b1 && gap < 2000);
    endtask

    task automatic drain(input string tag);
        tick_exp_t   e;
        int unsigned g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(g);
            check_val({tag, "_gap"}, g, {16'h0, e.gap});
            check_val({tag, "_cnt"}, {28'h0, bus.counter}, {28'h0, e.cnt});
            check_val({tag, "_running"}, {31'h0, bus.running}, 32'd1);
        end
    endtask

    task automatic toggle(input int row, input int step);
        bus.edit_toggle = 1'b1;
        bus.edit_row    = 3'(row);
        bus.edit_step   = 4'(step);
        @(negedge MCLK);
        bus.edit_toggle = 1'b0;
        if (row < 7) exp_rows[row][step] = ~exp_rows[row][step];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.poweron     = 1'b0;
        bus.run         = 1'b0;
        bus.bpm         = 8'd120;
        bus.edit_toggle = 1'b0;
        bus.edit_row    = 3'd0;
        bus.edit_step   = 4'd0;
        bus.clear_all   = 1'b0;
        for (int r = 0; r < 7; r++) exp_rows[r] = 16'h0;
        repeat (2) @(negedge MCLK);
        check_val("rst_counter", {28'h0, bus.counter}, 32'd0);
        check_val("rst_running", {31'h0, bus.running}, 32'd0);
        check_val("rst_tick", {31'h0, bus.step_tick}, 32'd0);
        check_rows("rst");
        reset = 1'b0;

        // 120 bpm: start tick one edge later, then every 125 cycles, wrapping 15->0
        bus.poweron = 1'b1;
        bus.run     = 1'b1;
        push_tick(1, 0);
        for (int i = 1; i <= 16; i++) push_tick(125, i % 16);
        drain("t120");

        // bpm 10 clamps to 40 -> 375 cycles per step
        bus.bpm = 8'd10;
        push_tick(375, 1);
        drain("tlow");

        // bpm 255 clamps to 240 -> 63/62 alternation
        bus.bpm = 8'd255;
        for (int i = 2; i <= 9; i++) push_tick((i % 2 == 0) ? 63 : 62, i);
        drain("thigh");

        // one-cycle drop of run at counter 9
        bus.run = 1'b0;
        @(negedge MCLK);
        check_val("stop_counter", {28'h0, bus.counter}, 32'd0);
        check_val("stop_running", {31'h0, bus.running}, 32'd0);
        check_val("stop_tick", {31'h0, bus.step_tick}, 32'd0);
        bus.run = 1'b1;
        push_tick(1, 0);
        drain("restart");

        // edits while stopped
        bus.run = 1'b0;
        @(negedge MCLK);
        toggle(2, 5);
        check_val("tog1_row2", {16'h0, bus.row2}, 32'h0020);
        check_rows("tog1");
        repeat (2) @(negedge MCLK);
        toggle(2, 5);
        check_rows("tog2");
        toggle(7, 3);
        check_rows("tog_row7");

        for (int s = 0; s < 16; s++) toggle(0, s);
        toggle(6, 15);
        check_val("fill_row0", {16'h0, bus.row0}, 32'hFFFF);
        check_rows("fill");

        // clear and toggle together: clear wins
        bus.clear_all   = 1'b1;
        bus.edit_toggle = 1'b1;
        bus.edit_row    = 3'd0;
        bus.edit_step   = 4'd0;
        @(negedge MCLK);
        bus.clear_all   = 1'b0;
        bus.edit_toggle = 1'b0;
        for (int r = 0; r < 7; r++) exp_rows[r] = 16'h0;
        check_rows("clr");

        // reset in the middle of a run at counter 6
        toggle(4, 3);
        bus.run = 1'b1;
        push_tick(1, 0);
        for (int i = 1; i <= 6; i++) push_tick((i % 2 == 1) ? 63 : 62, i);
        drain("prerst");
        reset = 1'b1;
        @(negedge MCLK);
        reset = 1'b0;
        for (int r = 0; r < 7; r++) exp_rows[r] = 16'h0;
        check_val("mrst_counter", {28'h0, bus.counter}, 32'd0);
        check_val("mrst_running", {31'h0, bus.running}, 32'd0);
        check_val("mrst_tick", {31'h0, bus.step_tick}, 32'd0);
        check_rows("mrst");
        push_tick(1, 0);
        drain("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
